// File: rtl/vreg_arb_pkg.sv
// rtl/vreg_arb_pkg.sv - shared types and group-expansion helpers for the vreg group arbiter
package vreg_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // vlmul values with this bit set are fractional/reserved and map to one register
  localparam int VLMUL_SINGLE_MSB = 2;

  // Result is left wide; the caller truncates to its address width (modulo wrap).
  function automatic logic [31:0] group_base(input logic [31:0] addr, input logic [2:0] vlmul);
    return vlmul[VLMUL_SINGLE_MSB] ? addr : (addr << vlmul[1:0]);
  endfunction

  function automatic logic [3:0] group_beats(input logic [2:0] vlmul);
    return vlmul[VLMUL_SINGLE_MSB] ? 4'd1 : (4'd1 << vlmul[1:0]);
  endfunction

endpackage

// File: rtl/vreg_group_arbiter_rr_arbiter.sv
// rtl/vreg_group_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  // Two passes: first the requesters at or above ptr, then the wrapped-around ones.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/vreg_group_arbiter.sv
// rtl/vreg_group_arbiter.sv - round-robin owner of one register-file port, expanding LMUL groups into beats
module vreg_group_arbiter
  import vreg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*3-1:0]          req_vlmul,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          port_stall,
  output logic                          port_valid,
  output logic [ADDR_WIDTH-1:0]         port_addr,
  output logic [ID_WIDTH-1:0]           port_id,
  output logic                          port_first,
  output logic                          port_last,
  output logic                          busy
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [2:0]            rem_q, rem_d;
  logic                  first_q, first_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;

  logic [NUM_REQ-1:0]    win_grant;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  win_any;
  logic                  last_beat;
  logic                  window;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_vlmul;
  logic [ADDR_WIDTH-1:0] grp_base;
  logic [3:0]            grp_beats;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_rr (
    .req  (req_valid),
    .ptr  (rr_q),
    .grant(win_grant),
    .idx  (win_idx),
    .any  (win_any)
  );

  assign last_beat = (state_q == BUSY) && (rem_q == 3'd0);
  // Gating with rst keeps req_ready quiet while reset is held.
  assign window    = rst && ((state_q == IDLE) || (last_beat && !port_stall));
  assign req_ready = window ? win_grant : '0;
  assign accept    = window && win_any;

  always_comb begin
    sel_addr  = '0;
    sel_vlmul = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_vlmul = req_vlmul[i*3 +: 3];
      end
    end
  end

  assign grp_base  = ADDR_WIDTH'(group_base(32'(sel_addr), sel_vlmul));
  assign grp_beats = group_beats(sel_vlmul);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    rem_d   = rem_q;
    first_d = first_q;
    rr_d    = rr_q;
    if (accept) begin
      state_d = BUSY;
      addr_d  = grp_base;
      id_d    = win_idx;
      rem_d   = 3'(grp_beats - 4'd1);
      first_d = 1'b1;
      rr_d    = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end else if ((state_q == BUSY) && !port_stall) begin
      first_d = 1'b0;
      if (rem_q != 3'd0) begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 3'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      rr_q    <= rr_d;
    end
  end

  assign port_valid = (state_q == BUSY);
  assign busy       = (state_q == BUSY);
  assign port_addr  = addr_q;
  assign port_id    = id_q;
  assign port_first = first_q;
  assign port_last  = last_beat;

endmodule

// File: tb/tb_vreg_group_arbiter.sv
// tb/tb_vreg_group_arbiter.sv - scoreboard bench for vreg_group_arbiter
module tb_vreg_group_arbiter;

  localparam int AW = 5;
  localparam int NR = 3;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*3-1:0] req_vlmul;
  logic [NR-1:0]  req_ready;
  logic           port_stall;
  logic           port_valid;
  logic [AW-1:0]  port_addr;
  logic [IW-1:0]  port_id;
  logic           port_first;
  logic           port_last;
  logic           busy;

  always #5 clk = ~clk;

  vreg_group_arbiter #(.ADDR_WIDTH(AW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_vlmul (req_vlmul),
    .req_ready (req_ready),
    .port_stall(port_stall),
    .port_valid(port_valid),
    .port_addr (port_addr),
    .port_id   (port_id),
    .port_first(port_first),
    .port_last (port_last),
    .busy      (busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic          first;
    logic          last;
    logic          follow;
  } beat_t;

  beat_t beat_q[$];
  int    grant_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    done     = 1'b0;
  bit    saw_first;
  logic [AW-1:0] saw_addr;

  task automatic push_beat(input int a, input int id, input int f, input int l, input int fo);
    beat_t b;
    b.addr   = AW'(a);
    b.id     = IW'(id);
    b.first  = 1'(f);
    b.last   = 1'(l);
    b.follow = 1'(fo);
    beat_q.push_back(b);
  endtask

  task automatic push_group(input int base, input int n, input int id, input int fo);
    for (int k = 0; k < n; k++)
      push_beat(base + k, id, (k == 0) ? 1 : 0, (k == n - 1) ? 1 : 0, (k == 0) ? fo : 1);
  endtask

  task automatic request(input int i, input int a, input int vl);
    req_addr[i*AW +: AW] = AW'(a);
    req_vlmul[i*3 +: 3]  = 3'(vl);
    req_valid[i]         = 1'b1;
  endtask

  // One cycle: note accepted requesters at the negedge, drop them after the edge.
  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc       = req_valid & req_ready;
    saw_first = port_valid && port_first;
    saw_addr  = port_addr;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic step_until_first(input int a);
    for (int k = 0; k < 40; k++) begin
      step();
      if (saw_first && (saw_addr == AW'(a))) break;
    end
  endtask

  // Monitor / scoreboard
  int            cycles = 0;
  bit            prev_valid, prev_stall, prev_ready;
  logic [AW+IW+1:0] prev_out;

  always @(negedge clk) begin
    beat_t e;
    int    g;
    cycles++;
    if (!rst) begin
      checks++;
      if ({port_valid, port_addr, port_id, port_first, port_last, busy, req_ready} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got v=%0b a=%0d id=%0d f=%0b l=%0b busy=%0b rdy=%b, expected all zero",
                 port_valid, port_addr, port_id, port_first, port_last, busy, req_ready);
      end
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      prev_ready = 1'b0;
    end else begin
      checks++;
      if (busy !== port_valid) begin
        failures++;
        $display("FAIL busy_eq_valid: busy=%0b expected %0b", busy, port_valid);
      end
      if (prev_ready) begin
        checks++;
        if (!(port_valid && port_first)) begin
          failures++;
          $display("FAIL accept_latency: valid=%0b first=%0b expected 1 1", port_valid, port_first);
        end
      end
      if (prev_stall && prev_valid) begin
        checks++;
        if ({port_valid, port_addr, port_id, port_first, port_last} !== {1'b1, prev_out}) begin
          failures++;
          $display("FAIL stall_freeze: got a=%0d id=%0d f=%0b l=%0b v=%0b expected a=%0d id=%0d f=%0b l=%0b v=1",
                   port_addr, port_id, port_first, port_last, port_valid,
                   prev_out[AW+IW+1:IW+2], prev_out[IW+1:2], prev_out[1], prev_out[0]);
        end
      end
      if (port_stall && port_valid) begin
        checks++;
        if (req_ready !== '0) begin
          failures++;
          $display("FAIL stall_ready: req_ready=%b expected 000", req_ready);
        end
      end
      if (|req_ready) begin
        checks++;
        if (grant_q.size() == 0) begin
          failures++;
          $display("FAIL grant_unexpected: req_ready=%b expected none", req_ready);
        end else begin
          g = grant_q.pop_front();
          if (req_ready !== (NR'(1) << g)) begin
            failures++;
            $display("FAIL grant_order: req_ready=%b expected id %0d", req_ready, g);
          end
        end
      end
      if (prev_valid && !prev_stall && (beat_q.size() > 0) && beat_q[0].follow) begin
        checks++;
        if (!port_valid) begin
          failures++;
          $display("FAIL no_bubble: port_valid=0 expected 1 (next beat addr %0d)", beat_q[0].addr);
        end
      end
      if (port_valid && !port_stall) begin
        checks++;
        if (beat_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: addr=%0d id=%0d expected no beat", port_addr, port_id);
        end else begin
          e = beat_q.pop_front();
          if ({port_addr, port_id, port_first, port_last} !== {e.addr, e.id, e.first, e.last}) begin
            failures++;
            $display("FAIL beat: got a=%0d id=%0d f=%0b l=%0b expected a=%0d id=%0d f=%0b l=%0b",
                     port_addr, port_id, port_first, port_last, e.addr, e.id, e.first, e.last);
          end
        end
      end
      prev_valid = port_valid;
      prev_stall = port_stall;
      prev_ready = |req_ready;
      prev_out   = {port_addr, port_id, port_first, port_last};
    end
    if (done || cycles > 3000) begin
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL timeout: cycles=%0d expected under 3000", cycles);
      end
      checks++;
      if (beat_q.size() != 0) begin
        failures++;
        $display("FAIL beats_left: %0d expected 0", beat_q.size());
      end
      checks++;
      if (grant_q.size() != 0) begin
        failures++;
        $display("FAIL grants_left: %0d expected 0", grant_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_vlmul  = '0;
    port_stall = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // All three single-register requests from rr_ptr=0
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2);
    push_beat(1, 0, 1, 1, 0);
    push_beat(2, 1, 1, 1, 1);
    push_beat(3, 2, 1, 1, 1);
    request(0, 1, 0); request(1, 2, 0); request(2, 3, 0);
    repeat (6) step();

    // LMUL=2 group: addr 3 -> regs 6,7
    grant_q.push_back(0);
    push_group(6, 2, 0, 0);
    request(0, 3, 1);
    repeat (5) step();

    // rr_ptr=1: requester 2 first (40 mod 32 = 8), then 0 (base 24), back to back
    grant_q.push_back(2); grant_q.push_back(0);
    push_group(8, 8, 2, 0);
    push_group(24, 8, 0, 1);
    request(0, 3, 3); request(2, 5, 3);
    repeat (20) step();

    // Reserved vlmul values collapse to a single beat at the raw address
    grant_q.push_back(1); grant_q.push_back(2);
    push_beat(17, 1, 1, 1, 0);
    push_beat(9, 2, 1, 1, 1);
    request(1, 17, 5); request(2, 9, 4);
    repeat (5) step();

    // Stall two cycles on the last beat while requester 1 waits
    grant_q.push_back(0); grant_q.push_back(1);
    push_group(4, 2, 0, 0);
    push_beat(6, 1, 1, 1, 1);
    request(0, 2, 1); request(1, 6, 0);
    step_until_first(4);
    port_stall = 1'b1;
    step(); step();
    port_stall = 1'b0;
    repeat (4) step();

    // Reset during beat 2 of a 4-beat group, with another request pending
    grant_q.push_back(2); grant_q.push_back(0);
    push_beat(4, 2, 1, 0, 0);
    push_beat(10, 0, 1, 1, 0);
    request(2, 1, 2);
    step_until_first(4);
    request(0, 10, 0);
    #2;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    repeat (5) step();

    done = 1'b1;
  end

endmodule
